// File: rtl/loopback_checker.sv
// loopback_checker: self-aligning tx->rx loopback checker.
// Searches the tx history for the chain latency, locks, then accumulates saturating error statistics.
`default_nettype none

module loopback_checker #(
  parameter int DATA_W  = 8,
  parameter int MAX_LAT = 16,
  parameter int LAT_W   = 4,
  parameter int CNT_W   = 16,
  parameter int LOCK_N  = 4,
  parameter int LOSS_N  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              lock,
  output logic [LAT_W-1:0]  latency,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic              sat
);

  localparam int MC_W = $clog2(LOCK_N + 1);
  localparam int MS_W = $clog2(LOSS_N + 1);
  localparam int PC_W = $clog2(DATA_W + 1);
  localparam logic [LAT_W:0]   FILL_MAX = (LAT_W+1)'(MAX_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hist [MAX_LAT];
  logic [LAT_W-1:0]  wp;
  logic [LAT_W:0]    fill;
  logic [MC_W-1:0]   match_cnt, match_cnt_nxt, match_inc;
  logic [MS_W-1:0]   miss_cnt, miss_cnt_nxt, miss_inc;
  logic [LAT_W-1:0]  latency_nxt;
  logic              lock_nxt;
  logic [LAT_W-1:0]  ref_idx;
  logic [DATA_W-1:0] ref_word;
  logic [DATA_W-1:0] diff;
  logic              match;
  logic [PC_W-1:0]   pop;
  logic [CNT_W-1:0]  sample_nxt, err_nxt, bit_nxt;
  logic [CNT_W:0]    bit_sum;

  // History contents need no reset; fill masks stale entries.
  always_ff @(posedge clk) begin
    if (tx_valid) hist[wp] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp   <= '0;
      fill <= '0;
    end else if (tx_valid) begin
      wp <= wp + 1'b1;
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  // Pre-write pointer: this cycle's tx word is not yet visible.
  always_comb begin
    ref_idx  = wp - latency - 1'b1;
    ref_word = hist[ref_idx];
    match    = ({1'b0, latency} < fill) && (rx_data == ref_word);
    diff     = rx_data ^ ref_word;
    pop      = '0;
    for (int i = 0; i < DATA_W; i++) pop = pop + PC_W'(diff[i]);
  end

  always_comb begin
    state_nxt     = state;
    latency_nxt   = latency;
    match_cnt_nxt = match_cnt;
    miss_cnt_nxt  = miss_cnt;
    lock_nxt      = lock;
    match_inc     = match_cnt + 1'b1;
    miss_inc      = miss_cnt + 1'b1;
    if (rx_valid) begin
      case (state)
        SEARCH, VERIFY: begin
          if (match) begin
            if (match_inc == MC_W'(LOCK_N)) begin
              state_nxt     = LOCKED;
              lock_nxt      = 1'b1;
              match_cnt_nxt = '0;
              miss_cnt_nxt  = '0;
            end else begin
              state_nxt     = VERIFY;
              match_cnt_nxt = match_inc;
            end
          end else begin
            state_nxt     = SEARCH;
            latency_nxt   = latency + 1'b1;
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_nxt = '0;
          end else if (miss_inc == MS_W'(LOSS_N)) begin
            state_nxt    = SEARCH;
            lock_nxt     = 1'b0;
            latency_nxt  = latency + 1'b1;
            miss_cnt_nxt = '0;
          end else begin
            miss_cnt_nxt = miss_inc;
          end
        end
        default: begin
          state_nxt     = SEARCH;
          lock_nxt      = 1'b0;
          match_cnt_nxt = '0;
          miss_cnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      latency   <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      lock      <= 1'b0;
    end else begin
      state     <= state_nxt;
      latency   <= latency_nxt;
      match_cnt <= match_cnt_nxt;
      miss_cnt  <= miss_cnt_nxt;
      lock      <= lock_nxt;
    end
  end

  always_comb begin
    sample_nxt = (sample_cnt == CNT_MAX) ? sample_cnt : sample_cnt + 1'b1;
    err_nxt    = err_cnt;
    bit_nxt    = bit_err_cnt;
    bit_sum    = {1'b0, bit_err_cnt} + (CNT_W+1)'(pop);
    if (!match) begin
      err_nxt = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
      bit_nxt = bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
      sat         <= 1'b0;
    end else if (clear) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
      sat         <= 1'b0;
    end else if (rx_valid && state == LOCKED) begin
      sample_cnt  <= sample_nxt;
      err_cnt     <= err_nxt;
      bit_err_cnt <= bit_nxt;
      sat         <= sat | (&sample_nxt) | (&err_nxt) | (&bit_nxt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_loopback_checker.sv
// tb_loopback_checker: table vectors, directed corner sequences and randomized traffic
// checked against a queue-based reference model for two parameterisations.
`default_nettype none

module tb_loopback_checker;

  localparam int MAX_LAT = 16;
  localparam int LOCK_N  = 4;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic        m_lock, s_lock, m_sat, s_sat;
  logic [3:0]  m_lat, s_lat;
  logic [15:0] m_samp, m_err, m_bit;
  logic [3:0]  s_samp, s_err, s_bit;

  loopback_checker #(.DATA_W(8), .MAX_LAT(16), .LAT_W(4), .CNT_W(16), .LOCK_N(4), .LOSS_N(3)) u_main (
    .clk(clk), .reset(reset), .clear(clear),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .lock(m_lock), .latency(m_lat), .sample_cnt(m_samp), .err_cnt(m_err),
    .bit_err_cnt(m_bit), .sat(m_sat)
  );

  loopback_checker #(.DATA_W(8), .MAX_LAT(16), .LAT_W(4), .CNT_W(4), .LOCK_N(4), .LOSS_N(32)) u_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .lock(s_lock), .latency(s_lat), .sample_cnt(s_samp), .err_cnt(s_err),
    .bit_err_cnt(s_bit), .sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic lock;
    int   lat;
    int   hits;
    int   misses;
    int   samples;
    int   errs;
    int   bits;
    logic sat;
  } mstate_t;

  typedef struct packed {
    logic        txv;
    logic [7:0]  txd;
    logic        rxv;
    logic [7:0]  rxd;
    logic        lk;
    logic [3:0]  lat;
    logic [15:0] samp;
  } vec_t;

  mstate_t mm, ms;
  int      hist_q[$];
  int      txlog[$];
  int      txcnt;
  int      n_vec = 0;
  int      n_err = 0;
  vec_t    tbl[11];

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference: the last MAX_LAT tx words live in hist_q; newest at the back.
  function automatic mstate_t model_step(mstate_t s, int cnt_max, int loss_n,
                                         bit clr, bit rxv, int rxd);
    int refw;
    bit hit;
    int nb;
    refw = 0; hit = 0; nb = 0;
    if (rxv) begin
      if (s.lat < hist_q.size()) begin
        refw = hist_q[hist_q.size() - 1 - s.lat];
        hit  = (refw == rxd);
        nb   = $countones(refw ^ rxd);
      end
      if (s.lock) begin
        s.samples = clampi(s.samples + 1, cnt_max);
        if (hit) begin
          s.misses = 0;
        end else begin
          s.errs   = clampi(s.errs + 1, cnt_max);
          s.bits   = clampi(s.bits + nb, cnt_max);
          s.misses = s.misses + 1;
          if (s.misses == loss_n) begin
            s.lock   = 1'b0;
            s.misses = 0;
            s.hits   = 0;
            s.lat    = (s.lat + 1) % MAX_LAT;
          end
        end
      end else if (hit) begin
        s.hits = s.hits + 1;
        if (s.hits == LOCK_N) begin
          s.lock   = 1'b1;
          s.hits   = 0;
          s.misses = 0;
        end
      end else begin
        s.hits = 0;
        s.lat  = (s.lat + 1) % MAX_LAT;
      end
    end
    if (clr) begin
      s.samples = 0; s.errs = 0; s.bits = 0; s.sat = 1'b0;
    end else if (s.samples == cnt_max || s.errs == cnt_max || s.bits == cnt_max) begin
      s.sat = 1'b1;
    end
    return s;
  endfunction

  task automatic compare_all();
    chk("main_lock", int'(m_lock), int'(mm.lock));
    chk("main_latency", int'(m_lat), mm.lat);
    chk("main_sample_cnt", int'(m_samp), mm.samples);
    chk("main_err_cnt", int'(m_err), mm.errs);
    chk("main_bit_err_cnt", int'(m_bit), mm.bits);
    chk("main_sat", int'(m_sat), int'(mm.sat));
    chk("sat_lock", int'(s_lock), int'(ms.lock));
    chk("sat_latency", int'(s_lat), ms.lat);
    chk("sat_sample_cnt", int'(s_samp), ms.samples);
    chk("sat_err_cnt", int'(s_err), ms.errs);
    chk("sat_bit_err_cnt", int'(s_bit), ms.bits);
    chk("sat_sat", int'(s_sat), int'(ms.sat));
  endtask

  // Entered at a falling edge; returns at the next falling edge with outputs checked.
  task automatic cyc(bit txv, logic [7:0] txd, bit rxv, logic [7:0] rxd, bit clr);
    tx_valid = txv; tx_data = txd; rx_valid = rxv; rx_data = rxd; clear = clr;
    @(posedge clk);
    if (reset) begin
      mm = model_step(mm, 65535, 3, clr, rxv, int'(rxd));
      ms = model_step(ms, 15, 32, clr, rxv, int'(rxd));
      if (txv) begin
        hist_q.push_back(int'(txd));
        if (hist_q.size() > MAX_LAT) void'(hist_q.pop_front());
      end
    end
    if (txv) txlog.push_back(int'(txd));
    @(negedge clk);
    compare_all();
  endtask

  // Counting tx words; rx is the word d positions behind the newest committed one.
  task automatic run_delay(int n, int d, logic [7:0] xm_first, logic [7:0] xm_rest, bit clr);
    logic [7:0] w, r, xm;
    bit         rv;
    for (int k = 0; k < n; k++) begin
      w  = txcnt[7:0];
      xm = (k == 0) ? xm_first : xm_rest;
      rv = (txlog.size() > d);
      r  = rv ? (8'(txlog[txlog.size() - 1 - d]) ^ xm) : 8'h00;
      cyc(1'b1, w, rv, r, clr);
      txcnt++;
    end
  endtask

  // Reset held low for a fraction of a cycle, outputs checked while it is low.
  task automatic async_reset_pulse(string tag);
    tx_valid = 1'b0; rx_valid = 1'b0; clear = 1'b0;
    #1 reset = 1'b0;
    mm = '0; ms = '0; hist_q.delete();
    #1;
    chk({tag, "_main_lock"}, int'(m_lock), 0);
    chk({tag, "_main_latency"}, int'(m_lat), 0);
    chk({tag, "_main_counts"}, int'(m_samp) + int'(m_err) + int'(m_bit) + int'(m_sat), 0);
    chk({tag, "_sat_lock"}, int'(s_lock), 0);
    chk({tag, "_sat_latency"}, int'(s_lat), 0);
    chk({tag, "_sat_counts"}, int'(s_samp) + int'(s_err) + int'(s_bit) + int'(s_sat), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    compare_all();
    txlog.delete();
    txcnt = 0;
  endtask

  initial begin
    // tx counts 0..10; rx is delayed so the locked latency is 3.
    tbl[0]  = '{1'b1, 8'd0,  1'b0, 8'd0, 1'b0, 4'd0, 16'd0};
    tbl[1]  = '{1'b1, 8'd1,  1'b0, 8'd0, 1'b0, 4'd0, 16'd0};
    tbl[2]  = '{1'b1, 8'd2,  1'b0, 8'd0, 1'b0, 4'd0, 16'd0};
    tbl[3]  = '{1'b1, 8'd3,  1'b0, 8'd0, 1'b0, 4'd0, 16'd0};
    tbl[4]  = '{1'b1, 8'd4,  1'b1, 8'd0, 1'b0, 4'd1, 16'd0};
    tbl[5]  = '{1'b1, 8'd5,  1'b1, 8'd1, 1'b0, 4'd2, 16'd0};
    tbl[6]  = '{1'b1, 8'd6,  1'b1, 8'd2, 1'b0, 4'd3, 16'd0};
    tbl[7]  = '{1'b1, 8'd7,  1'b1, 8'd3, 1'b0, 4'd3, 16'd0};
    tbl[8]  = '{1'b1, 8'd8,  1'b1, 8'd4, 1'b0, 4'd3, 16'd0};
    tbl[9]  = '{1'b1, 8'd9,  1'b1, 8'd5, 1'b0, 4'd3, 16'd0};
    tbl[10] = '{1'b1, 8'd10, 1'b1, 8'd6, 1'b1, 4'd3, 16'd0};

    mm = '0; ms = '0; txcnt = 0;
    reset = 1'b0; clear = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;

    // Lock acquisition
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].txv, tbl[i].txd, tbl[i].rxv, tbl[i].rxd, 1'b0);
      chk("tbl_lock", int'(m_lock), int'(tbl[i].lk));
      chk("tbl_latency", int'(m_lat), int'(tbl[i].lat));
      chk("tbl_sample_cnt", int'(m_samp), int'(tbl[i].samp));
    end
    txcnt = 11;

    // Error injection: one word XOR 0x05 then nine clean words
    run_delay(10, 3, 8'h05, 8'h00, 1'b0);
    chk("inj_sample_cnt", int'(m_samp), 10);
    chk("inj_err_cnt", int'(m_err), 1);
    chk("inj_bit_err_cnt", int'(m_bit), 2);
    chk("inj_lock", int'(m_lock), 1);

    // Loss after three misses, relock at the new latency
    run_delay(2, 5, 8'h00, 8'h00, 1'b0);
    chk("loss_lock_held", int'(m_lock), 1);
    run_delay(1, 5, 8'h00, 8'h00, 1'b0);
    chk("loss_lock_drop", int'(m_lock), 0);
    chk("loss_latency", int'(m_lat), 4);
    chk("loss_sample_cnt", int'(m_samp), 13);
    chk("loss_err_cnt", int'(m_err), 4);
    run_delay(4, 5, 8'h00, 8'h00, 1'b0);
    chk("relock_pending", int'(m_lock), 0);
    run_delay(1, 5, 8'h00, 8'h00, 1'b0);
    chk("relock_lock", int'(m_lock), 1);
    chk("relock_latency", int'(m_lat), 5);
    chk("relock_sample_cnt", int'(m_samp), 13);
    chk("relock_err_cnt", int'(m_err), 4);

    // Randomized traffic against the model
    begin
      int d;
      bit tv, rv, cl;
      logic [7:0] td, rd;
      d = 5;
      for (int i = 0; i < 3000; i++) begin
        if (i % 300 == 299) d = $urandom_range(0, 17);
        tv = ($urandom_range(0, 3) != 0);
        td = 8'($urandom);
        rv = ($urandom_range(0, 3) != 0);
        if (txlog.size() > d) rd = 8'(txlog[txlog.size() - 1 - d]);
        else rd = 8'($urandom);
        if ($urandom_range(0, 15) == 0) rd = rd ^ 8'($urandom_range(1, 255));
        cl = ($urandom_range(0, 63) == 0);
        cyc(tv, td, rv, rd, cl);
      end
    end

    // Out-of-range delay: never locks, latency walks 0..15 and wraps
    async_reset_pulse("rst_oor");
    run_delay(21, 20, 8'h00, 8'h00, 1'b0);
    chk("oor_start_latency", int'(m_lat), 0);
    for (int k = 1; k <= 40; k++) begin
      run_delay(1, 20, 8'h00, 8'h00, 1'b0);
      chk("oor_lock", int'(m_lock), 0);
      chk("oor_latency", int'(m_lat), k % 16);
    end

    // Saturation on the 4-bit instance, then clear
    async_reset_pulse("rst_sat");
    run_delay(11, 3, 8'h00, 8'h00, 1'b0);
    chk("sat_locked", int'(s_lock), 1);
    run_delay(20, 3, 8'hFF, 8'hFF, 1'b0);
    chk("sat_err_cnt_max", int'(s_err), 15);
    chk("sat_bit_err_cnt_max", int'(s_bit), 15);
    chk("sat_sample_cnt_max", int'(s_samp), 15);
    chk("sat_flag", int'(s_sat), 1);
    chk("sat_lock_kept", int'(s_lock), 1);
    run_delay(1, 3, 8'h00, 8'h00, 1'b1);
    chk("clr_sample_cnt", int'(s_samp), 0);
    chk("clr_err_cnt", int'(s_err), 0);
    chk("clr_bit_err_cnt", int'(s_bit), 0);
    chk("clr_sat", int'(s_sat), 0);
    chk("clr_lock", int'(s_lock), 1);
    chk("clr_latency", int'(s_lat), 3);

    // Async reset while locked, then full reacquisition
    async_reset_pulse("rst_midlock");
    run_delay(10, 3, 8'h00, 8'h00, 1'b0);
    chk("rearm_lock_pending", int'(s_lock), 0);
    run_delay(1, 3, 8'h00, 8'h00, 1'b0);
    chk("rearm_main_lock", int'(m_lock), 1);
    chk("rearm_sat_lock", int'(s_lock), 1);
    chk("rearm_latency", int'(m_lat), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
